// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue_if
//  Brief    : Bus bundle between the fetch queue and its upstream controller
//             and downstream core: program load, redirect, run control and
//             the valid/ready instruction stream.
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_queue_if #(
    parameter int AW         = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          run;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic [7:0]    instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic [CW-1:0] fifo_count;
    logic          halted;

    // Controller / consumer side
    modport master (
        output run, load_en, load_addr, load_data,
        output redirect_valid, redirect_pc, instr_ready,
        input  instr_valid, instr_data, instr_pc, fifo_count, halted
    );

    // Fetch queue side
    modport slave (
        input  run, load_en, load_addr, load_data,
        input  redirect_valid, redirect_pc, instr_ready,
        output instr_valid, instr_data, instr_pc, fifo_count, halted
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue
//  Brief    : Instruction-supply stage: loadable byte program memory, PC,
//             one-deep read pipeline and a prefetch FIFO presenting one byte
//             per valid/ready handshake. Supports redirect and HALT stop.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int         AW          = 4,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  wire logic          clk,
    input  wire logic          reset,
    instr_fetch_queue_if.slave bus
);
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;
    localparam int MEM_WORDS = 1 << AW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q;
    logic [7:0]    mem_q [MEM_WORDS];

    // Read pipeline stage: memory output register plus its tag
    logic [7:0]    rd_data_q;
    logic [AW-1:0] rd_pc_q;
    logic          rd_valid_q;

    // Prefetch FIFO
    logic [7:0]    fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;

    logic          fetching;
    logic          halted;
    logic [CW-1:0] occupancy;
    logic          issue;
    logic          push;
    logic          push_halt;
    logic          head_valid;
    logic          out_valid;
    logic          pop;

    // Entries queued plus the read still in flight must leave room, so the
    // FIFO can never overflow regardless of consumer behaviour.
    assign occupancy  = count_q + CW'(rd_valid_q);
    assign issue      = fetching && !bus.redirect_valid &&
                        (occupancy < CW'(FIFO_DEPTH));
    // Reads completing after the halt byte was queued are dropped.
    assign push       = rd_valid_q && (state_q != S_HALTED) && !bus.redirect_valid;
    assign push_halt  = push && (rd_data_q == HALT_OPCODE);
    assign head_valid = (count_q != '0);
    // A redirect hides the head so nothing transfers in the flush cycle.
    assign out_valid  = head_valid && !bus.redirect_valid;
    assign pop        = out_valid && bus.instr_ready;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; redirect outranks halt, halt outranks run=0
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.redirect_valid) state_d = S_IDLE;
                else if (push_halt)     state_d = S_HALTED;
                else if (bus.run)       state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.redirect_valid) state_d = bus.run ? S_FETCH : S_IDLE;
                else if (push_halt)     state_d = S_HALTED;
                else if (!bus.run)      state_d = S_IDLE;
            end
            S_HALTED: begin
                if (bus.redirect_valid) state_d = bus.run ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        fetching = (state_q == S_FETCH);
        halted   = (state_q == S_HALTED);
    end

    // Program memory: synchronous write, registered read (old data on collision)
    always_ff @(posedge clk) begin
        if (bus.load_en) mem_q[bus.load_addr] <= bus.load_data;
        if (issue)       rd_data_q <= mem_q[pc_q];
    end

    // PC, in-flight tag and FIFO pointers; redirect flushes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= '0;
            rd_pc_q    <= '0;
            rd_valid_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            rd_valid_q <= issue;
            if (issue) rd_pc_q <= pc_q;
            if (bus.redirect_valid) begin
                pc_q    <= bus.redirect_pc;
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (issue) pc_q   <= pc_q + AW'(1);
                if (push)  wptr_q <= wptr_q + PW'(1);
                if (pop)   rptr_q <= rptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // FIFO storage; contents are only observed through a nonzero count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wptr_q] <= rd_data_q;
            fifo_pc_q[wptr_q]   <= rd_pc_q;
        end
    end

    assign bus.instr_valid = out_valid;
    assign bus.instr_data  = head_valid ? fifo_data_q[rptr_q] : 8'h00;
    assign bus.instr_pc    = head_valid ? fifo_pc_q[rptr_q] : '0;
    assign bus.fifo_count  = count_q;
    assign bus.halted      = halted;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_queue
//  Brief    : Directed self-checking bench for instr_fetch_queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;
    localparam int AW         = 4;
    localparam int FIFO_DEPTH = 4;

    logic clk;
    logic reset;

    instr_fetch_queue_if #(.AW(AW), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    instr_fetch_queue #(
        .AW(AW), .FIFO_DEPTH(FIFO_DEPTH), .HALT_OPCODE(8'hFF)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int q_data[$];
    int q_pc[$];
    int q_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int a, input int d);
        bus.load_en   = 1'b1;
        bus.load_addr = AW'(a);
        bus.load_data = 8'(d);
        tick();
        bus.load_en   = 1'b0;
    endtask

    task automatic redirect_to(input int pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(pc);
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    // Record every transfer (valid & ready at the sampling point) for ncyc cycles
    task automatic collect(input int ncyc);
        q_data.delete(); q_pc.delete(); q_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (bus.instr_valid && bus.instr_ready) begin
                q_data.push_back(int'(bus.instr_data));
                q_pc.push_back(int'(bus.instr_pc));
                q_cyc.push_back(c);
            end
            tick();
        end
    endtask

    task automatic wait_count(input int want, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (int'(bus.fifo_count) == want) found = 1'b1;
            else tick();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        reset              = 1'b1;
        bus.run            = 1'b0;
        bus.load_en        = 1'b0;
        bus.load_addr      = '0;
        bus.load_data      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid",  32'(bus.instr_valid), 32'd0);
        chk("rst_count",  32'(bus.fifo_count),  32'd0);
        chk("rst_halted", 32'(bus.halted),      32'd0);
        chk("rst_data",   32'(bus.instr_data),  32'd0);
        chk("rst_pc",     32'(bus.instr_pc),    32'd0);
        reset = 1'b0;

        // ---- program with HALT at address 3 ----
        load(0, 8'h10); load(1, 8'h21); load(2, 8'h32); load(3, 8'hFF); load(4, 8'h44);
        bus.run = 1'b1; bus.instr_ready = 1'b1;
        tick(); tick();
        chk("lat_e2_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("lat_e3_valid", 32'(bus.instr_valid), 32'd1);
        chk("lat_e3_data",  32'(bus.instr_data),  32'h10);
        collect(10);
        chk("halt_n", 32'(q_data.size()), 32'd4);
        if (q_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("halt_data", 32'(q_data[i]), (i == 0) ? 32'h10 : (i == 1) ? 32'h21 :
                                                 (i == 2) ? 32'h32 : 32'hFF);
                chk("halt_pc",  32'(q_pc[i]),  32'(i));
                chk("halt_cyc", 32'(q_cyc[i]), 32'(i));
            end
        end
        chk("halt_flag",  32'(bus.halted),      32'd1);
        chk("halt_empty", 32'(bus.instr_valid), 32'd0);

        // ---- leave HALTED via redirect to 2 with run=1 ----
        redirect_to(2);
        chk("hr_halted", 32'(bus.halted), 32'd0);
        tick(); tick();
        chk("hr_valid", 32'(bus.instr_valid), 32'd1);
        chk("hr_data",  32'(bus.instr_data),  32'h32);
        chk("hr_pc",    32'(bus.instr_pc),    32'd2);
        collect(6);
        chk("hr_n", 32'(q_data.size()), 32'd2);
        chk("hr_halted2", 32'(bus.halted), 32'd1);

        // ---- write to address 1 in the cycle it is read ----
        redirect_to(1);
        bus.load_en = 1'b1; bus.load_addr = AW'(1); bus.load_data = 8'h77;
        tick();
        bus.load_en = 1'b0;
        tick();
        chk("rbw_old_data", 32'(bus.instr_data), 32'h21);
        chk("rbw_old_pc",   32'(bus.instr_pc),   32'd1);
        collect(6);
        chk("rbw_n", 32'(q_data.size()), 32'd3);
        redirect_to(1);
        tick(); tick();
        chk("rbw_new_data", 32'(bus.instr_data), 32'h77);
        collect(6);

        // ---- saturation and PC wrap ----
        for (int a = 0; a < 16; a++) load(a, a);
        bus.instr_ready = 1'b0;
        redirect_to(0);
        repeat (8) tick();
        chk("sat_count", 32'(bus.fifo_count), 32'd4);
        chk("sat_valid", 32'(bus.instr_valid), 32'd1);
        chk("sat_data",  32'(bus.instr_data),  32'h00);
        chk("sat_pc",    32'(bus.instr_pc),    32'd0);
        bus.instr_ready = 1'b1;
        collect(18);
        chk("wrap_n", 32'(q_data.size()), 32'd18);
        if (q_data.size() == 18) begin
            for (int i = 0; i < 18; i++) begin
                chk("wrap_data", 32'(q_data[i]), 32'(i % 16));
                chk("wrap_pc",   32'(q_pc[i]),   32'(i % 16));
            end
        end

        // ---- redirect with 3 entries queued ----
        bus.instr_ready = 1'b0;
        load(8, 8'h5A);
        wait_count(3, "rd_wait3");
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(8);
        #1;
        chk("rd_forced_invalid", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("rd_flush_count", 32'(bus.fifo_count),  32'd0);
        chk("rd_flush_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("rd_kill_count", 32'(bus.fifo_count), 32'd0);
        tick();
        chk("rd_new_valid", 32'(bus.instr_valid), 32'd1);
        chk("rd_new_data",  32'(bus.instr_data),  32'h5A);
        chk("rd_new_pc",    32'(bus.instr_pc),    32'd8);

        // ---- asynchronous reset mid-operation ----
        bus.instr_ready = 1'b0;
        wait_count(2, "ar_wait2");
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid",  32'(bus.instr_valid), 32'd0);
        chk("ar_count",  32'(bus.fifo_count),  32'd0);
        chk("ar_halted", 32'(bus.halted),      32'd0);
        bus.run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) tick();
        chk("ar_idle_valid", 32'(bus.instr_valid), 32'd0);
        bus.run = 1'b1;
        tick(); tick();
        chk("ar_e2_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("ar_e3_valid", 32'(bus.instr_valid), 32'd1);
        chk("ar_e3_data",  32'(bus.instr_data),  32'h00);
        chk("ar_e3_pc",    32'(bus.instr_pc),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
